// File: rtl/intr_pkg.sv
// Shared widths, the "no source" encoding and the number-to-mask helper
// used by the interrupt controller and its priority encoders.
package intr_pkg;

   localparam int NUM_IRQ = 3;
   localparam int INTNO_W = 2;

   typedef logic [NUM_IRQ-1:0] irq_vec_t;
   typedef logic [INTNO_W-1:0] intno_t;

   localparam intno_t INT_NONE = 2'd0;

   // Source n (1..NUM_IRQ) lives in bit n-1; INT_NONE maps to an empty mask.
   function automatic irq_vec_t src_mask(input intno_t n);
      irq_vec_t v;
      v = '0;
      if (n != INT_NONE) v[n - 2'd1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/intr_controller_if.sv
// Request/acknowledge bundle between interrupt sources, the controller and the CPU.
interface intr_controller_if;
   import intr_pkg::*;

   irq_vec_t irq;
   logic     intr_ack;
   intno_t   clrNo;
   intno_t   IntNo;
   logic     IntrRequest;
   irq_vec_t pending;
   irq_vec_t in_service;

   modport master (
      output irq, intr_ack, clrNo,
      input  IntNo, IntrRequest, pending, in_service
   );

   modport slave (
      input  irq, intr_ack, clrNo,
      output IntNo, IntrRequest, pending, in_service
   );
endinterface

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: highest set bit of a source vector as a source
// number (source 3 highest), INT_NONE when the vector is empty.
module intr_prio_enc
   import intr_pkg::*;
(
   input  irq_vec_t i_vec,
   output intno_t   o_num
);

   // NOTE: the default first keeps every path assigned, so no latch is inferred.
   always_comb begin
      o_num = INT_NONE;
      if      (i_vec[2]) o_num = 2'd3;
      else if (i_vec[1]) o_num = 2'd2;
      else if (i_vec[0]) o_num = 2'd1;
   end

endmodule

// File: rtl/intr_controller.sv
// Nesting interrupt controller: edge-latched pending requests, fixed priority,
// a registered CPU request with ack, and in-service tracking cleared by clrNo.
module intr_controller
   import intr_pkg::*;
(
   input logic               clk,
   input logic               rst,
   intr_controller_if.slave  bus
);

   irq_vec_t r_irq_prev;
   irq_vec_t r_pending;
   irq_vec_t r_in_service;
   logic     r_intr_request;
   intno_t   r_int_no;

   irq_vec_t w_rise;
   logic     w_ack;
   irq_vec_t w_ack_mask;
   irq_vec_t w_clr_mask;
   intno_t   w_win;
   intno_t   w_cur_level;
   logic     w_eligible;

   intr_prio_enc u_win_enc (
      .i_vec (r_pending),
      .o_num (w_win)
   );

   intr_prio_enc u_level_enc (
      .i_vec (r_in_service),
      .o_num (w_cur_level)
   );

   assign w_rise     = bus.irq & ~r_irq_prev;
   assign w_ack      = bus.intr_ack & r_intr_request;
   assign w_ack_mask = w_ack ? src_mask(r_int_no) : '0;
   assign w_clr_mask = src_mask(bus.clrNo);
   assign w_eligible = (w_win > w_cur_level);

   // NOTE: non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq_prev     <= bus.irq;
         r_pending      <= '0;
         r_in_service   <= '0;
         r_intr_request <= 1'b0;
         r_int_no       <= INT_NONE;
      end else begin
         r_irq_prev   <= bus.irq;
         // A fresh edge on the acked source re-arms it; an ack beats a clear.
         r_pending    <= (r_pending & ~w_ack_mask) | w_rise;
         r_in_service <= (r_in_service & ~w_clr_mask) | w_ack_mask;
         if (w_ack) begin
            r_intr_request <= 1'b0;
            r_int_no       <= INT_NONE;
         end else begin
            r_intr_request <= w_eligible;
            r_int_no       <= w_eligible ? w_win : INT_NONE;
         end
      end
   end

   assign bus.IntNo       = r_int_no;
   assign bus.IntrRequest = r_intr_request;
   assign bus.pending     = r_pending;
   assign bus.in_service  = r_in_service;

endmodule

// File: tb/tb_intr_controller.sv
// Directed scoreboard bench for intr_controller: each step pushes the expected
// post-edge state, then pops and compares it one time unit after the edge.
module tb_intr_controller;
   import intr_pkg::*;

   typedef struct {
      string    tag;
      irq_vec_t pend;
      irq_vec_t ins;
      logic     req;
      intno_t   no;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   exp_t sb[$];

   intr_controller_if bus ();

   intr_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs at negedge, queue the expectation, compare after posedge.
   task automatic step(input string tag, input logic [2:0] irq_v, input logic ack,
                       input logic [1:0] clr, input logic rst_v,
                       input logic [2:0] e_pend, input logic [2:0] e_ins,
                       input logic e_req, input logic [1:0] e_no);
      exp_t e;
      @(negedge clk);
      rst          = rst_v;
      bus.irq      = irq_v;
      bus.intr_ack = ack;
      bus.clrNo    = clr;
      sb.push_back('{tag, e_pend, e_ins, e_req, e_no});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".queue"}, 8'd0, 8'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, ".pending"},    {5'd0, bus.pending},     {5'd0, e.pend});
         check({e.tag, ".in_service"}, {5'd0, bus.in_service},  {5'd0, e.ins});
         check({e.tag, ".IntrReq"},    {7'd0, bus.IntrRequest}, {7'd0, e.req});
         check({e.tag, ".IntNo"},      {6'd0, bus.IntNo},       {6'd0, e.no});
      end
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      rst          = 1'b1;
      bus.irq      = '0;
      bus.intr_ack = 1'b0;
      bus.clrNo    = '0;

      //    tag          irq    ack clr  rst  pend   ins    req no
      step("reset0",    3'b000, 0, 2'd0, 1, 3'b000, 3'b000, 0, 2'd0);
      step("reset1",    3'b000, 0, 2'd0, 1, 3'b000, 3'b000, 0, 2'd0);

      // Single request, ack, clear, stray ack
      step("s_idle",    3'b000, 0, 2'd0, 0, 3'b000, 3'b000, 0, 2'd0);
      step("s_rise",    3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 0, 2'd0);
      step("s_req",     3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 1, 2'd1);
      step("s_hold",    3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 1, 2'd1);
      step("s_ack",     3'b001, 1, 2'd0, 0, 3'b000, 3'b001, 0, 2'd0);
      step("s_insvc",   3'b000, 0, 2'd0, 0, 3'b000, 3'b001, 0, 2'd0);
      step("s_clr",     3'b000, 0, 2'd1, 0, 3'b000, 3'b000, 0, 2'd0);
      step("s_strayak", 3'b000, 1, 2'd0, 0, 3'b000, 3'b000, 0, 2'd0);

      // Nesting: source 2 interrupts source 1's handler
      step("n_rise1",   3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 0, 2'd0);
      step("n_req1",    3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 1, 2'd1);
      step("n_ack1",    3'b001, 1, 2'd0, 0, 3'b000, 3'b001, 0, 2'd0);
      step("n_rise2",   3'b011, 0, 2'd0, 0, 3'b010, 3'b001, 0, 2'd0);
      step("n_req2",    3'b011, 0, 2'd0, 0, 3'b010, 3'b001, 1, 2'd2);
      step("n_ack2",    3'b011, 1, 2'd0, 0, 3'b000, 3'b011, 0, 2'd0);
      step("n_clr2",    3'b011, 0, 2'd2, 0, 3'b000, 3'b001, 0, 2'd0);
      step("n_clr1",    3'b011, 0, 2'd1, 0, 3'b000, 3'b000, 0, 2'd0);

      // Blocked lower priority behind source 3
      step("b_low",     3'b000, 0, 2'd0, 0, 3'b000, 3'b000, 0, 2'd0);
      step("b_rise3",   3'b100, 0, 2'd0, 0, 3'b100, 3'b000, 0, 2'd0);
      step("b_req3",    3'b100, 0, 2'd0, 0, 3'b100, 3'b000, 1, 2'd3);
      step("b_ack3",    3'b100, 1, 2'd0, 0, 3'b000, 3'b100, 0, 2'd0);
      step("b_rise1",   3'b101, 0, 2'd0, 0, 3'b001, 3'b100, 0, 2'd0);
      step("b_blocked", 3'b101, 0, 2'd0, 0, 3'b001, 3'b100, 0, 2'd0);
      step("b_clr3",    3'b101, 0, 2'd3, 0, 3'b001, 3'b000, 0, 2'd0);
      step("b_req1",    3'b101, 0, 2'd0, 0, 3'b001, 3'b000, 1, 2'd1);

      // Preemption of an outstanding request for source 1
      step("p_hold1",   3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 1, 2'd1);
      step("p_rise3",   3'b101, 0, 2'd0, 0, 3'b101, 3'b000, 1, 2'd1);
      step("p_req3",    3'b101, 0, 2'd0, 0, 3'b101, 3'b000, 1, 2'd3);
      step("p_ack3",    3'b101, 1, 2'd0, 0, 3'b001, 3'b100, 0, 2'd0);
      step("p_wait",    3'b101, 0, 2'd0, 0, 3'b001, 3'b100, 0, 2'd0);
      step("p_clr3",    3'b101, 0, 2'd3, 0, 3'b001, 3'b000, 0, 2'd0);
      step("p_req1",    3'b101, 0, 2'd0, 0, 3'b001, 3'b000, 1, 2'd1);
      step("p_ack1",    3'b101, 1, 2'd0, 0, 3'b000, 3'b001, 0, 2'd0);
      step("p_clr1",    3'b101, 0, 2'd1, 0, 3'b000, 3'b000, 0, 2'd0);

      // Simultaneous ack and new edge, ack and clear
      step("m_low",     3'b000, 0, 2'd0, 0, 3'b000, 3'b000, 0, 2'd0);
      step("m_rise2",   3'b010, 0, 2'd0, 0, 3'b010, 3'b000, 0, 2'd0);
      step("m_req2",    3'b010, 0, 2'd0, 0, 3'b010, 3'b000, 1, 2'd2);
      step("m_drop2",   3'b000, 0, 2'd0, 0, 3'b010, 3'b000, 1, 2'd2);
      step("m_ackrise", 3'b010, 1, 2'd0, 0, 3'b010, 3'b010, 0, 2'd0);
      step("m_noreq",   3'b010, 0, 2'd0, 0, 3'b010, 3'b010, 0, 2'd0);
      step("m_clr2",    3'b010, 0, 2'd2, 0, 3'b010, 3'b000, 0, 2'd0);
      step("m_rereq2",  3'b010, 0, 2'd0, 0, 3'b010, 3'b000, 1, 2'd2);
      step("m_ackclr",  3'b010, 1, 2'd2, 0, 3'b000, 3'b010, 0, 2'd0);
      step("m_clr2b",   3'b000, 0, 2'd2, 0, 3'b000, 3'b000, 0, 2'd0);
      step("d_rise1",   3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 0, 2'd0);
      step("d_req1",    3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 1, 2'd1);
      step("d_ack1",    3'b001, 1, 2'd0, 0, 3'b000, 3'b001, 0, 2'd0);
      step("d_rise2",   3'b011, 0, 2'd0, 0, 3'b010, 3'b001, 0, 2'd0);
      step("d_req2",    3'b011, 0, 2'd0, 0, 3'b010, 3'b001, 1, 2'd2);
      step("d_ack2clr1",3'b011, 1, 2'd1, 0, 3'b000, 3'b010, 0, 2'd0);
      step("d_clr2",    3'b011, 0, 2'd2, 0, 3'b000, 3'b000, 0, 2'd0);

      // Reset in the middle of nested handling, irq held high through it
      step("r_low",     3'b000, 0, 2'd0, 0, 3'b000, 3'b000, 0, 2'd0);
      step("r_rise1",   3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 0, 2'd0);
      step("r_req1",    3'b001, 0, 2'd0, 0, 3'b001, 3'b000, 1, 2'd1);
      step("r_ack1",    3'b001, 1, 2'd0, 0, 3'b000, 3'b001, 0, 2'd0);
      step("r_rise2",   3'b011, 0, 2'd0, 0, 3'b010, 3'b001, 0, 2'd0);
      step("r_req2",    3'b011, 0, 2'd0, 0, 3'b010, 3'b001, 1, 2'd2);
      step("r_ack2",    3'b011, 1, 2'd0, 0, 3'b000, 3'b011, 0, 2'd0);
      step("r_rise3",   3'b111, 0, 2'd0, 0, 3'b100, 3'b011, 0, 2'd0);
      step("r_req3",    3'b111, 0, 2'd0, 0, 3'b100, 3'b011, 1, 2'd3);
      step("r_reset",   3'b111, 1, 2'd1, 1, 3'b000, 3'b000, 0, 2'd0);
      step("r_after0",  3'b111, 0, 2'd0, 0, 3'b000, 3'b000, 0, 2'd0);
      step("r_after1",  3'b111, 0, 2'd0, 0, 3'b000, 3'b000, 0, 2'd0);

      check("sb_drained", 8'(sb.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/intr_controller.md
INTR_CONTROLLER -- requirements
Module: intr_controller

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; clock port clk, reset port rst.
REQ-002 The module SHALL expose these ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- irq  in  3  raw request levels; bit i-1 = source i (sources 1..3).
- intr_ack  in  1  CPU has accepted the current request and entered its handler.
- clrNo  in  2  source whose service ends (uret path); 0 = no clear.
- IntNo  out  2  number of the requested source (1..3); 0 when none.
- IntrRequest  out  1  request to CPU, held until acknowledged.
- pending  out  3  latched, not-yet-accepted requests.
- in_service  out  3  accepted, not-yet-cleared sources (nesting state).

Function
REQ-003 The block SHALL register irq each cycle as irq_prev; a rising edge (irq[i]=1, irq_prev[i]=0) SHALL set pending[i] at that clock edge.
REQ-004 Priority SHALL be fixed: source 3 highest, source 1 lowest.
REQ-005 cur_level SHALL be the highest-numbered set bit of in_service, 0 if none.
REQ-006 win SHALL be the highest-numbered set bit of pending, 0 if none; a request is eligible when win > cur_level.
REQ-007 IntNo and IntrRequest SHALL be registered: each edge, IntrRequest <= eligible and IntNo <= (eligible ? win : 0), except as REQ-009 requires.
REQ-008 Latency: irq rising edge sampled at edge k -> pending set after edge k -> IntrRequest=1 and IntNo valid after edge k+1.
REQ-009 On an edge with intr_ack=1 and IntrRequest=1: clear pending[IntNo], set in_service[IntNo], force IntrRequest<=0 and IntNo<=0 for that edge. No duplicate request cycle is allowed.
REQ-010 intr_ack while IntrRequest=0 SHALL be ignored.
REQ-011 clrNo!=0 SHALL clear in_service[clrNo] at that edge; clrNo naming a bit that is not set is a no-op.
REQ-012 Simultaneous ack and clrNo on the same source: the set SHALL win. On different sources, both actions SHALL take effect.
REQ-013 A new rising edge on source i at the same edge as its ack SHALL leave pending[i]=1, so the source is re-requested later.
REQ-014 A rising edge on a source already pending SHALL have no further effect; there is no counting.
REQ-015 A higher-priority arrival while a request is outstanding SHALL update IntNo at the next edge; IntrRequest stays 1.
REQ-016 Nesting depth is 3 by construction. A lower- or equal-priority source stays pending until cur_level drops below it via clrNo.
REQ-017 IntNo SHALL be stable while IntrRequest=1, unless REQ-015 applies.

Reset
REQ-018 With rst=1 at an edge, the block SHALL set pending=0, in_service=0, IntrRequest=0, IntNo=0, and irq_prev=irq (prevents a spurious edge after reset).
REQ-019 rst SHALL override intr_ack, clrNo and irq edges at the same edge; a reset mid-handler drops all nesting state.

Structure
REQ-020 The shared package intr_pkg SHALL hold NUM_IRQ=3, INTNO_W=2 and the INT_NONE=0 encoding, also used by the clear logic.
REQ-021 Fixed-priority encoding (3-bit vector -> 2-bit number, 0 if empty) SHALL be one sub-module, intr_prio_enc, instantiated twice (for win and cur_level).
REQ-022 No other sub-modules are required; the target size is about 150-250 lines of RTL.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single request: irq=3'b001 rises at edge 5 -> pending=001 after edge 5; IntrRequest=1, IntNo=1 after edge 6; ack at edge 8 -> pending=000, in_service=001, IntrRequest=0 after edge 8; clrNo=1 -> in_service=000.
- Nesting: source 1 in service, irq[1] (source 2) rises -> IntNo=2 two edges later; ack -> in_service=011; clrNo=2 -> in_service=001; clrNo=1 -> 000.
- Blocked lower priority: in_service=100, source 1 rises -> pending=001, IntrRequest stays 0; clrNo=3 -> IntrRequest=1, IntNo=1 one edge after the clear.
- Preemption of an outstanding request: IntNo=1 requested, no ack, source 3 rises -> IntNo=3 with IntrRequest held 1; ack -> in_service=100, pending=001.
- Simultaneous events: ack of source 2 plus a new irq[1] edge at the same edge -> pending[1]=1, in_service[1]=1; ack on source 2 with clrNo=2 at the same edge -> in_service[1]=1.
- Reset mid-operation: in_service=011, pending=100, IntrRequest=1, rst=1 for one edge -> all outputs 0; irq held high through reset -> no request afterwards.
